ifetch: RTL and testbench

Instruction fetch stage of the MIPS pipeline, directly upstream of the decode stage. Holds the program counter and fetches instruction words from instruction memory over a request/grant/acknowledge handshake. Buffers fetched words in a 2-entry queue and presents them to decode with a valid/ready handshake. Redirects on taken branches and jumps, discarding stale in-flight data.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/ifetch_buf.sv | 69 ++++++
 rtl/ifetch.sv | 116 +++++++++++
 tb/tb_ifetch.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ==================================================================
// mips_pkg : shared types and constants for the MIPS fetch slice
// Revision : 1.0
// ==================================================================
package mips_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_JAL = 6'b000011;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT       = 2'd1,
    WAIT_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;

  function automatic logic is_jump(input logic [XLEN-1:0] word);
    return (word[31:26] == OPC_J) || (word[31:26] == OPC_JAL);
  endfunction

  // Pseudo-direct target: region bits come from the jump's own PC+4.
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc4,
                                                  input logic [XLEN-1:0] word);
    return {pc4[31:28], word[25:0], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_buf.sv
`default_nettype none
// ==================================================================
// ifetch_buf : 2-entry FIFO of {ins, pc4}; flush beats push
// Revision   : 1.0
// ==================================================================
module ifetch_buf
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != 2'd2);
    do_pop   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ==================================================================
// ifetch   : MIPS fetch stage - PC, imem req/gnt/ack, decode queue
// Option   : IFETCH_EARLY_JUMP_EN redirects on a pushed j/jal word
// Revision : 1.0
// ==================================================================
module ifetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            Imem_req,
  output logic [XLEN-1:0] Imem_addr,
  input  logic            Imem_gnt,
  input  logic            Imem_ack,
  input  logic [XLEN-1:0] Imem_rdata,
  input  logic            Br_taken,
  input  logic [XLEN-1:0] Br_target,
  output logic [XLEN-1:0] Ins,
  output logic [XLEN-1:0] Pc4,
  output logic            Ins_valid,
  input  logic            ID_ready
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fly_pc_q, fly_pc_d;

  logic [XLEN-1:0] fly_pc4;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] ej_target;
  logic            ack_kept, push, pop, ej, can_issue, req_int, grant;
  logic [1:0]      count, count_next;
  fetch_entry_t    buf_din, buf_head;

  always_comb begin
    fly_pc4    = fly_pc_q + 32'd4;
    ack_kept   = Imem_ack && (state_q == WAIT);
    push       = ack_kept && !Br_taken;
    pop        = Ins_valid && ID_ready;
    count_next = count + {1'b0, push} - {1'b0, pop};
`ifdef IFETCH_EARLY_JUMP_EN
    ej         = push && is_jump(Imem_rdata);
    ej_target  = jump_target(fly_pc4, Imem_rdata);
`else
    ej         = 1'b0;
    ej_target  = pc_q;
`endif
    fetch_addr = ej ? ej_target : pc_q;
    // A new request may only leave once the outstanding one has returned.
    can_issue  = (state_q == IDLE) ||
                 (Imem_ack && ((state_q == WAIT) || (state_q == WAIT_FLUSH)));
    req_int    = !Br_taken && can_issue && (count_next < 2'd2);
    grant      = req_int && Imem_gnt;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fly_pc_d = fly_pc_q;
    if (Br_taken) begin
      pc_d = Br_target;
      if (state_q != IDLE) begin
        state_d = Imem_ack ? IDLE : WAIT_FLUSH;
      end
    end else begin
      if (ej) begin
        pc_d = ej_target;
      end
      if (grant) begin
        pc_d     = fetch_addr + 32'd4;
        fly_pc_d = fetch_addr;
        state_d  = WAIT;
      end else if (Imem_ack && (state_q != IDLE)) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      fly_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fly_pc_q <= fly_pc_d;
    end
  end

  assign buf_din.ins = Imem_rdata;
  assign buf_din.pc4 = fly_pc4;

  ifetch_buf u_buf (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push),
    .pop   (pop),
    .flush (Br_taken),
    .din   (buf_din),
    .head  (buf_head),
    .count (count)
  );

  // Request is forced low while reset is held, independent of state.
  assign Imem_req  = RST && req_int;
  assign Imem_addr = fetch_addr;
  assign Ins_valid = (count != 2'd0);
  assign Ins       = Ins_valid ? buf_head.ins : '0;
  assign Pc4       = Ins_valid ? buf_head.pc4 : '0;

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ==================================================================
// tb_ifetch : directed + randomized bench; expected instruction stream
//             is rebuilt from a memory function and redirect events
// Revision  : 1.0
// ==================================================================
module tb_ifetch;
  import mips_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef IFETCH_EARLY_JUMP_EN
  localparam bit EJ = 1'b1;
`else
  localparam bit EJ = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_gnt = 1'b0;
  logic        Imem_ack = 1'b0;
  logic [31:0] Imem_rdata = 32'h0;
  logic        Br_taken = 1'b0;
  logic [31:0] Br_target = 32'h0;
  logic [31:0] Ins;
  logic [31:0] Pc4;
  logic        Ins_valid;
  logic        ID_ready = 1'b0;

  ifetch #(.RESET_PC(RPC)) dut (
    .CLK(CLK), .RST(RST),
    .Imem_req(Imem_req), .Imem_addr(Imem_addr), .Imem_gnt(Imem_gnt),
    .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
    .Br_taken(Br_taken), .Br_target(Br_target),
    .Ins(Ins), .Pc4(Pc4), .Ins_valid(Ins_valid), .ID_ready(ID_ready)
  );

  always #5 CLK = ~CLK;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // stimulus knobs
  logic        br = 1'b0, rdy = 1'b0;
  logic [31:0] tgt = 32'h0;
  int unsigned cfg_gnt_pct = 0;
  int unsigned cfg_lat = 0;
  bit          cfg_lat_rand = 1'b0;
  bit          jw_en = 1'b0;

  // memory responder
  bit          mem_out = 1'b0, mem_ovr_v = 1'b0, ovr_next = 1'b0, stray = 1'b0;
  logic [31:0] mem_addr = 32'h0, mem_ovr = 32'h0;
  int unsigned mem_cnt = 0;

  // per-cycle samples and previous-cycle copies
  logic        s_req, s_vld, s_gnt, s_ack;
  logic [31:0] s_addr, s_ins, s_pc4;
  logic        p_req = 1'b0, p_gnt = 1'b0, p_vld = 1'b0, p_rdy = 1'b0, p_br = 1'b0;
  logic [31:0] p_addr = 32'h0, p_ins = 32'h0, p_pc4 = 32'h0;

  // address of the next instruction decode should receive
  logic [31:0] exp_pc = RPC;

  function automatic logic [31:0] memw(input logic [31:0] a);
    logic [31:0] w;
    if (jw_en && (a == 32'h10)) return 32'h0800_0400;
    w = (a * 32'h9E37_79B1) ^ 32'hA5C3_0F69;
    if (w[31:27] == 5'b00001) w[31] = 1'b1;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        ack_now;
    logic [31:0] w;
    logic [31:0] nxt;
    @(negedge CLK);
    ack_now    = mem_out && (mem_cnt == 0);
    Imem_ack   = ack_now;
    Imem_rdata = ack_now ? (mem_ovr_v ? mem_ovr : memw(mem_addr)) : $urandom;
    Br_taken   = br;
    Br_target  = tgt;
    ID_ready   = rdy;
    #1;
    s_req  = Imem_req;
    s_addr = Imem_addr;
    s_ins  = Ins;
    s_pc4  = Pc4;
    s_vld  = Ins_valid;
    s_ack  = ack_now;
    Imem_gnt = ($urandom_range(99, 0) < cfg_gnt_pct);
    s_gnt  = Imem_gnt && s_req;

    if (s_req) chk("one_outstanding", {31'b0, mem_out && !ack_now && !stray}, 32'd0);
    if (p_req && !p_gnt && !br) begin
      chk("req_hold", {31'b0, s_req}, 32'd1);
      chk("addr_hold", s_addr, p_addr);
    end
    if (p_vld && !p_rdy && !p_br) begin
      chk("vld_hold", {31'b0, s_vld}, 32'd1);
      chk("ins_hold", s_ins, p_ins);
      chk("pc4_hold", s_pc4, p_pc4);
    end
    if (!s_vld) begin
      chk("ins_zero", s_ins, 32'h0);
      chk("pc4_zero", s_pc4, 32'h0);
    end
    if (s_vld && rdy) begin
      w = memw(exp_pc);
      chk("stream_ins", s_ins, w);
      chk("stream_pc4", s_pc4, exp_pc + 32'd4);
      nxt = exp_pc + 32'd4;
      if (EJ && (w[31:27] == 5'b00001)) nxt = {nxt[31:28], w[25:0], 2'b00};
      exp_pc = nxt;
    end
    if (br) exp_pc = tgt;

    if (ack_now) begin
      mem_out = 1'b0; mem_ovr_v = 1'b0; stray = 1'b0;
    end else if (mem_out && (mem_cnt > 0)) begin
      mem_cnt--;
    end
    if (s_gnt) begin
      mem_out   = 1'b1;
      mem_addr  = s_addr;
      mem_cnt   = cfg_lat_rand ? $urandom_range(3, 0) : cfg_lat;
      mem_ovr_v = ovr_next;
      ovr_next  = 1'b0;
    end
    p_req = s_req; p_gnt = s_gnt; p_addr = s_addr; p_vld = s_vld;
    p_ins = s_ins; p_pc4 = s_pc4; p_rdy = rdy; p_br = br;
  endtask

  // Run with no grants until nothing is outstanding and the queue is empty.
  task automatic drain();
    int n;
    n = 0;
    cfg_gnt_pct = 0; br = 1'b0; rdy = 1'b1;
    do begin
      tick();
      n++;
    end while ((mem_out || s_vld || s_ack) && (n < 20));
    chk("drain_timeout", {31'b0, (mem_out || s_vld || s_ack)}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int          n;

    // ---- reset values
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_req", {31'b0, Imem_req}, 32'd0);
    chk("rst_addr", Imem_addr, RPC);
    chk("rst_vld", {31'b0, Ins_valid}, 32'd0);
    chk("rst_ins", Ins, 32'h0);
    chk("rst_pc4", Pc4, 32'h0);
    RST = 1'b1;

    // ---- sequential fetch, 1-cycle ack, decode always ready
    cfg_gnt_pct = 100; cfg_lat = 0; rdy = 1'b1;
    tick();
    chk("t0_req", {31'b0, s_req}, 32'd1);
    chk("t0_addr", s_addr, 32'h0);
    tick();
    chk("t1_addr", s_addr, 32'h4);
    chk("t1_vld", {31'b0, s_vld}, 32'd0);
    tick();
    chk("t2_addr", s_addr, 32'h8);
    chk("t2_vld", {31'b0, s_vld}, 32'd1);
    chk("t2_pc4", s_pc4, 32'h4);
    tick();
    chk("t3_pc4", s_pc4, 32'h8);
    tick();
    chk("t4_pc4", s_pc4, 32'hC);

    // ---- decode stalls 5 cycles: queue fills, requests stop
    rdy = 1'b0;
    tick();
    held = s_ins;
    chk("stall_head", s_ins, memw(32'hC));
    chk("stall_req0", {31'b0, s_req}, 32'd0);
    repeat (4) begin
      tick();
      chk("stall_req", {31'b0, s_req}, 32'd0);
      chk("stall_ins", s_ins, held);
    end
    rdy = 1'b1;
    tick();
    chk("unstall_req", {31'b0, s_req}, 32'd1);
    chk("unstall_addr", s_addr, 32'h14);
    tick();
    chk("unstall_pc4", s_pc4, 32'h14);

    // ---- branch while waiting; late ack must be dropped
    drain();
    cfg_gnt_pct = 100; cfg_lat = 2; ovr_next = 1'b1; mem_ovr = 32'hDEAD_BEEF;
    tick();
    chk("bw_req", {31'b0, s_req}, 32'd1);
    br = 1'b1; tgt = 32'h100;
    tick();
    chk("bw_br_req", {31'b0, s_req}, 32'd0);
    br = 1'b0; cfg_lat = 0;
    tick();
    chk("bw_flush_req", {31'b0, s_req}, 32'd0);
    tick();
    chk("bw_ack_req", {31'b0, s_req}, 32'd1);
    chk("bw_ack_addr", s_addr, 32'h100);
    tick();
    chk("bw_vld", {31'b0, s_vld}, 32'd0);
    tick();
    chk("bw_ins", s_ins, memw(32'h100));
    chk("bw_pc4", s_pc4, 32'h104);

    // ---- branch in the same cycle as an ack with words queued
    drain();
    cfg_gnt_pct = 100; cfg_lat = 0; rdy = 1'b0;
    tick();
    tick();
    chk("ba_req", {31'b0, s_req}, 32'd1);
    br = 1'b1; tgt = 32'h100;
    tick();
    chk("ba_br_req", {31'b0, s_req}, 32'd0);
    br = 1'b0;
    tick();
    chk("ba_vld", {31'b0, s_vld}, 32'd0);
    chk("ba_req2", {31'b0, s_req}, 32'd1);
    chk("ba_addr", s_addr, 32'h100);

    // ---- jump word at 0x10
    drain();
    jw_en = 1'b1;
    br = 1'b1; tgt = 32'h10;
    tick();
    br = 1'b0; cfg_gnt_pct = 100; cfg_lat = 0;
    tick();
    chk("j_addr", s_addr, 32'h10);
    tick();
    chk("j_next_req", {31'b0, s_req}, 32'd1);
    chk("j_next_addr", s_addr, EJ ? 32'h1000 : 32'h14);
    tick();
    chk("j_ins", s_ins, 32'h0800_0400);
    chk("j_pc4", s_pc4, 32'h14);
    drain();
    jw_en = 1'b0;

    // ---- wrap around the top of the address space
    br = 1'b1; tgt = 32'hFFFF_FFF8;
    tick();
    br = 1'b0; cfg_gnt_pct = 100; cfg_lat = 0;
    repeat (4) tick();
    chk("wrap_addr", s_addr, 32'h0000_0004);

    // ---- randomized traffic
    cfg_lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cfg_gnt_pct = 60 + $urandom_range(40, 0);
      rdy = ($urandom_range(3, 0) != 0);
      br  = ($urandom_range(15, 0) == 0);
      tgt = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      tick();
    end
    cfg_lat_rand = 1'b0;

    // ---- reset pulse with a word queued and a request in flight
    drain();
    rdy = 1'b0; cfg_gnt_pct = 100; cfg_lat = 0;
    tick();
    cfg_lat = 3;
    tick();
    @(posedge CLK);
    #2;
    RST = 1'b0;
    Imem_gnt = 1'b0; Imem_ack = 1'b0;
    #1;
    chk("mrst_req", {31'b0, Imem_req}, 32'd0);
    chk("mrst_addr", Imem_addr, RPC);
    chk("mrst_vld", {31'b0, Ins_valid}, 32'd0);
    chk("mrst_ins", Ins, 32'h0);
    chk("mrst_pc4", Pc4, 32'h0);
    exp_pc = RPC; stray = mem_out;
    p_req = 1'b0; p_gnt = 1'b0; p_vld = 1'b0; p_br = 1'b0;
    @(negedge CLK);
    #1;
    RST = 1'b1;
    cfg_gnt_pct = 0; rdy = 1'b1;
    n = 0;
    while (mem_out && (n < 10)) begin
      tick();
      n++;
      chk("stray_req", {31'b0, s_req}, 32'd1);
      chk("stray_addr", s_addr, RPC);
    end
    chk("stray_timeout", {31'b0, mem_out}, 32'd0);
    cfg_gnt_pct = 100; cfg_lat = 0;
    repeat (3) tick();
    chk("restart_vld", {31'b0, s_vld}, 32'd1);
    chk("restart_ins", s_ins, memw(RPC));
    chk("restart_pc4", s_pc4, RPC + 32'd4);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
